// File: rtl/decode_pkg.sv
// Shared types and constants for the ARM-style decode stage.
package decode_pkg;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_MEM = 2'b01,
        CLS_BR  = 2'b10,
        CLS_UND = 2'b11
    } instr_class_t;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t    R15_IDX   = 4'd15;
    localparam logic [31:0] PC_OFFSET = 32'd8;
    localparam logic [3:0]  CMD_CMP   = 4'b1010;

    typedef struct packed {
        reg_idx_t     a1;
        reg_idx_t     a2;
        reg_idx_t     a3;
        logic [31:0]  r15;
        logic [31:0]  imm;
        logic         regw;
        logic         memw;
        instr_class_t cls;
    } bundle_t;

endpackage

// File: rtl/decode_stage_hazard_scoreboard.sv
// Pending-write scoreboard for decode_stage; only built with DECODE_HAZARD_EN.
module hazard_scoreboard
    import decode_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     chk_valid,
    input  reg_idx_t src1,
    input  reg_idx_t src2,
    input  reg_idx_t dst,
    input  logic     use_src1,
    input  logic     use_src2,
    input  logic     use_dst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    output logic     hazard
);

    logic [15:0] pending;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;

    assign set_mask = set_en ? (16'd1 << set_idx) : 16'd0;
    assign clr_mask = clr_en ? (16'd1 << clr_idx) : 16'd0;

    // A set and a clear on the same register in one cycle leaves it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign hazard = chk_valid && ((use_src1 && pending[src1]) ||
                                  (use_src2 && pending[src2]) ||
                                  (use_dst  && pending[dst]));

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage with valid/ready handshake and flush.
// Define DECODE_HAZARD_EN to add the pending-write scoreboard and stall counter.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        out_ready,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    output logic        out_valid,
    output logic [3:0]  out_A1,
    output logic [3:0]  out_A2,
    output logic [3:0]  out_A3,
    output logic [31:0] out_R15,
    output logic [31:0] out_imm,
    output logic        out_regw,
    output logic        out_memw,
    output logic [1:0]  out_class,
    output logic [15:0] stall_cnt
);

    function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t b;
        b.cls  = instr_class_t'(instr[27:26]);
        b.a1   = instr[19:16];
        b.a3   = instr[15:12];
        b.a2   = (b.cls == CLS_MEM) ? instr[15:12] : instr[3:0];
        b.r15  = pc + PC_OFFSET;
        b.regw = 1'b0;
        b.memw = 1'b0;
        b.imm  = '0;
        case (b.cls)
            CLS_DP: begin
                b.regw = (instr[24:21] != CMD_CMP);
                b.imm  = {24'd0, instr[7:0]};
            end
            CLS_MEM: begin
                b.regw = instr[20];
                b.memw = !instr[20];
                b.imm  = {20'd0, instr[11:0]};
            end
            CLS_BR:  b.imm = {{6{instr[23]}}, instr[23:0], 2'b00};
            default: b.imm = '0;
        endcase
        return b;
    endfunction

    bundle_t dec_p0;
    bundle_t bundle_p1;
    logic    vld_p1;
    logic    hazard;
    logic    accept;

    assign dec_p0   = decode(in_instr, in_pc);
    assign in_ready = !rst && (!vld_p1 || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // p0 -> p1: output register; flush wins over a simultaneous accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            bundle_p1 <= dec_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef DECODE_HAZARD_EN
    logic use_src1;
    logic use_src2;

    assign use_src1 = (dec_p0.cls == CLS_DP) || (dec_p0.cls == CLS_MEM);
    assign use_src2 = (dec_p0.cls == CLS_DP) || dec_p0.memw;

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .chk_valid(in_valid),
        .src1     (dec_p0.a1),
        .src2     (dec_p0.a2),
        .dst      (dec_p0.a3),
        .use_src1 (use_src1),
        .use_src2 (use_src2),
        .use_dst  (dec_p0.regw),
        .set_en   (accept && dec_p0.regw && (dec_p0.a3 != R15_IDX)),
        .set_idx  (dec_p0.a3),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .hazard   (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    logic unused_wb;

    assign unused_wb = ^{wb_valid, wb_rd};
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif

    assign out_valid = vld_p1;
    assign out_A1    = bundle_p1.a1;
    assign out_A2    = bundle_p1.a2;
    assign out_A3    = bundle_p1.a3;
    assign out_R15   = bundle_p1.r15;
    assign out_imm   = bundle_p1.imm;
    assign out_regw  = bundle_p1.regw;
    assign out_memw  = bundle_p1.memw;
    assign out_class = bundle_p1.cls;

endmodule
